// File: rtl/pipeline_stall_controller_pkg.sv
// Shared hazard package: FSM encoding, register-index width and the MUL/DIV timeout default.
package pipeline_stall_controller_pkg;

    localparam int unsigned REG_W              = 5;
    localparam int unsigned MD_TIMEOUT_DEFAULT = 40;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Hazard-unit bus: pipeline status in, stall/flush/bubble controls and status out.
interface pipeline_stall_controller_if #(
    parameter int unsigned CNT_W = 32
);
    import pipeline_stall_controller_pkg::*;

    logic [REG_W-1:0] ID_RS1;
    logic [REG_W-1:0] ID_RS2;
    logic             ID_USES_RS1;
    logic             ID_USES_RS2;
    logic             EX_MEMREAD;
    logic [REG_W-1:0] EX_RD;
    logic             EX_MULDIV_START;
    logic             MULDIV_DONE;
    logic             BRANCH_TAKEN;

    logic             PC_STALL;
    logic             IFID_STALL;
    logic             IDEX_STALL;
    logic             IDEX_BUBBLE;
    logic             IFID_FLUSH;
    logic             EXMEM_BUBBLE;
    logic             MD_TIMEOUT_ERR;
    logic [CNT_W-1:0] STALL_CYCLES;

    // Pipeline side
    modport master (
        output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_MEMREAD, EX_RD,
               EX_MULDIV_START, MULDIV_DONE, BRANCH_TAKEN,
        input  PC_STALL, IFID_STALL, IDEX_STALL, IDEX_BUBBLE, IFID_FLUSH,
               EXMEM_BUBBLE, MD_TIMEOUT_ERR, STALL_CYCLES
    );

    // Controller side
    modport slave (
        input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_MEMREAD, EX_RD,
               EX_MULDIV_START, MULDIV_DONE, BRANCH_TAKEN,
        output PC_STALL, IFID_STALL, IDEX_STALL, IDEX_BUBBLE, IFID_FLUSH,
               EXMEM_BUBBLE, MD_TIMEOUT_ERR, STALL_CYCLES
    );

endinterface

// File: rtl/pipeline_stall_controller_load_use_detect.sv
// Load-use comparator: ID operand depends on a load currently in EX (x0 never matches).
module load_use_detect
    import pipeline_stall_controller_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    output logic             hazard_c
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_match = id_uses_rs2 && (id_rs2 == ex_rd);
    assign hazard_c  = ex_memread && (ex_rd != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline hazard unit: load-use bubble, taken-branch flush and MUL/DIV wait with timeout.
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                         CLK,
    input  logic                         RESET,
    pipeline_stall_controller_if.slave   bus
);

    localparam int unsigned TO_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    logic [TO_W-1:0]   to_cnt_q;
    logic [TO_W-1:0]   to_cnt_d;
    logic              err_q;
    logic              err_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic              load_use_c;
    logic              pc_stall_c;
    logic              ifid_stall_c;
    logic              idex_stall_c;
    logic              idex_bubble_c;
    logic              ifid_flush_c;
    logic              exmem_bubble_c;

    load_use_detect u_load_use_detect (
        .id_rs1      (bus.ID_RS1),
        .id_rs2      (bus.ID_RS2),
        .id_uses_rs1 (bus.ID_USES_RS1),
        .id_uses_rs2 (bus.ID_USES_RS2),
        .ex_memread  (bus.EX_MEMREAD),
        .ex_rd       (bus.EX_RD),
        .hazard_c    (load_use_c)
    );

    // State register, timeout counter, sticky error and saturating stall counter
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            to_cnt_q    <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
            if (pc_stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    // Next state and stall/flush controls; everything forced quiet while RESET is high
    always_comb begin
        state_d        = state_q;
        to_cnt_d       = to_cnt_q;
        err_d          = err_q;
        pc_stall_c     = 1'b0;
        ifid_stall_c   = 1'b0;
        idex_stall_c   = 1'b0;
        idex_bubble_c  = 1'b0;
        ifid_flush_c   = 1'b0;
        exmem_bubble_c = 1'b0;

        if (!RESET) begin
            case (state_q)
                ST_RUN: begin
                    if (bus.BRANCH_TAKEN) begin
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                    end else begin
                        if (load_use_c) begin
                            pc_stall_c    = 1'b1;
                            ifid_stall_c  = 1'b1;
                            idex_bubble_c = 1'b1;
                        end
                        // A same-cycle done means a zero-wait op: no MD_WAIT needed
                        if (bus.EX_MULDIV_START && !bus.MULDIV_DONE) begin
                            state_d  = ST_MD_WAIT;
                            to_cnt_d = '0;
                        end
                    end
                end
                ST_MD_WAIT: begin
                    pc_stall_c     = 1'b1;
                    ifid_stall_c   = 1'b1;
                    idex_stall_c   = 1'b1;
                    exmem_bubble_c = 1'b1;
                    if (bus.MULDIV_DONE) begin
                        state_d = ST_RUN;
                    end else if (to_cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    assign bus.PC_STALL       = pc_stall_c;
    assign bus.IFID_STALL     = ifid_stall_c;
    assign bus.IDEX_STALL     = idex_stall_c;
    assign bus.IDEX_BUBBLE    = idex_bubble_c;
    assign bus.IFID_FLUSH     = ifid_flush_c;
    assign bus.EXMEM_BUBBLE   = exmem_bubble_c;
    assign bus.MD_TIMEOUT_ERR = err_q;
    assign bus.STALL_CYCLES   = stall_cnt_q;

endmodule
